sensor_uart_arbiter: RTL and testbench
======================================

// Module: sensor_uart_arbiter
//
// PURPOSE
//   Round-robin arbiter that shares one byte-wide UART transmitter among
//   N_SENSORS sensor controllers.
//   Grants one requester, latches its 16-bit frame and sends it as two
//   bytes (MSB first). Pulses that sensor's ack when the frame is done.
//   Sits between the per-sensor controller buffers and uart_tx.
//
// PARAMETERS
//   N_SENSORS    8          number of requesters (power of 2, >=2)
//   WORD_W       16         frame width per sensor: 4 cmd + 5 addr + 7 data
//   IDX_W        3          log2(N_SENSORS)
//   TIMEOUT_CYC  1_000_000  max cycles waiting for tx_done (timeout build only)
//
// PORTS
//   clk         in   1               system clock, 50 MHz
//   rst         in   1               synchronous reset, active-high
//   req         in   N_SENSORS       per-sensor "buffer ready" level
//   sensor_bus  in   N_SENSORS*16    sensor i frame at [16*i+15 : 16*i]
//   ack         out  N_SENSORS       one-cycle pulse: frame i consumed
//   tx_busy     in   1               UART tx busy; must not start a byte
//   tx_done     in   1               one-cycle pulse: byte fully shifted out
//   tx_start    out  1               one-cycle pulse: load tx_byte
//   tx_byte     out  8               byte to transmit; valid when tx_start=1
//   grant_idx   out  IDX_W           index of the sensor holding the UART
//   busy        out  1               1 in any state except IDLE
//   err_timeout out  1               sticky timeout flag (0 without macro)
//
// BEHAVIOUR
//   - Reset (sync, rst=1 at posedge):
//     - State -> IDLE; rr_ptr=0.
//     - ack=0, tx_start=0, tx_byte=0, grant_idx=0, busy=0, err_timeout=0.
//     - Reset mid-transfer abandons the frame. No ack is issued.
//   - State machine transitions:
//     - IDLE -> SEND_HI: when req!=0.
//       Pick the first set req at or after rr_ptr, with modulo wrap.
//       Register grant_idx and latch frame = sensor_bus slice.
//     - SEND_HI -> WAIT_HI: when tx_busy=0.
//       tx_start=1 and tx_byte=frame[15:8] for exactly that cycle.
//     - WAIT_HI -> SEND_LO: on tx_done=1.
//     - SEND_LO -> WAIT_LO: as SEND_HI, but tx_byte=frame[7:0].
//     - WAIT_LO -> ACK: on tx_done=1.
//     - ACK -> IDLE: ack[grant_idx]=1 for one cycle.
//       rr_ptr = grant_idx+1 (wraps N_SENSORS-1 -> 0).
//   - Latency:
//     - req sampled at edge t -> grant_idx valid after edge t+1.
//     - First tx_start no earlier than the cycle after t+1.
//     - ack is asserted the cycle after the final tx_done.
//   - Boundaries:
//     - req deasserting after grant is ignored: the latched frame is sent.
//     - sensor_bus changes after grant do not affect tx_byte.
//     - tx_done outside WAIT_HI/WAIT_LO is ignored.
//     - tx_done coincident with tx_start is ignored; it does not count for
//       the new byte.
//     - A requester re-asserting req in its ACK cycle is not re-granted
//       first when others wait; rr_ptr has already moved past it.
//     - req all-zero: stay in IDLE. rr_ptr unchanged.
//     - At most one ack bit is set in any cycle.
//     - tx_start never asserts while tx_busy=1.
//
// CONFIGURATION
//   SENSOR_ARB_TIMEOUT_EN
//     - Defined:
//       - A cycle counter runs in WAIT_HI/WAIT_LO and clears on state entry.
//       - When it reaches TIMEOUT_CYC-1 with no tx_done:
//         err_timeout=1 (sticky until rst), then go to ACK.
//         The sensor is acked so it is not starved; the frame is dropped.
//     - Undefined: no counter exists; err_timeout is tied to 0.
//       WAIT states wait indefinitely.
//
// STRUCTURE
//   - Package sensor_arb_pkg holds:
//     - state enum: IDLE, SEND_HI, WAIT_HI, SEND_LO, WAIT_LO, ACK
//     - WORD_W, BYTE_W=8
//     - byte-order constants HI_FIRST
//   - Sub-module rr_pick: combinational round-robin priority select.
//     - Inputs: req, rr_ptr.
//     - Outputs: any, idx.
//     - Instantiated once.
//   - The FSM, frame register and optional timeout counter live in the top.
//
// TESTING
//   1. Single requester: req=8'h04, slice 2 = 16'hA55A.
//      -> grant_idx=2; bytes A5 then 5A; ack=8'h04 one cycle after the
//         2nd tx_done.
//   2. Fairness: req=8'hFF held, model UART done 10 cycles after start.
//      -> grant order 0,1,...,7,0; each index once per 8 frames.
//   3. Wrap: rr_ptr=7 (after sensor 6 served), req=8'h81.
//      -> sensor 7 granted before sensor 0.
//   4. Backpressure: tx_busy=1 for 50 cycles after grant.
//      -> tx_start stays 0 for those 50 cycles, then pulses once.
//      Changing sensor_bus mid-frame leaves tx_byte unchanged.
//   5. Reset mid-frame: rst during WAIT_LO.
//      -> next cycle: all outputs 0, state IDLE, no ack pulse.
//   6. Timeout (SENSOR_ARB_TIMEOUT_EN, TIMEOUT_CYC=100): no tx_done.
//      -> err_timeout=1 after 100 WAIT_HI cycles; ack pulses; arbiter
//         serves the next req.

Source files
------------

// File: rtl/sensor_arb_pkg.sv
// ============================================================================
//  Module : sensor_arb_pkg
//  Brief  : Shared types and constants for the sensor-to-UART arbiter.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package sensor_arb_pkg;

    localparam int WORD_W = 16;
    localparam int BYTE_W = 8;

    // Frame is serialised high byte first.
    localparam bit HI_FIRST = 1'b1;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SEND_HI = 3'd1,
        WAIT_HI = 3'd2,
        SEND_LO = 3'd3,
        WAIT_LO = 3'd4,
        ACK     = 3'd5
    } arb_state_t;

    function automatic logic [BYTE_W-1:0] frame_byte(
        input logic [WORD_W-1:0] frame,
        input logic              second
    );
        logic sel_hi;
        sel_hi = HI_FIRST ^ second;
        return sel_hi ? frame[WORD_W-1 -: BYTE_W] : frame[BYTE_W-1:0];
    endfunction

endpackage

`default_nettype wire

// File: rtl/sensor_uart_arbiter_if.sv
// ============================================================================
//  Module : sensor_uart_arbiter_if
//  Brief  : Sensor-side and UART-side signals of the arbiter.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface sensor_uart_arbiter_if #(
    parameter int N_SENSORS = 8,
    parameter int IDX_W     = 3
);
    logic [N_SENSORS-1:0]    req;
    logic [N_SENSORS*16-1:0] sensor_bus;
    logic [N_SENSORS-1:0]    ack;
    logic                    tx_busy;
    logic                    tx_done;
    logic                    tx_start;
    logic [7:0]              tx_byte;
    logic [IDX_W-1:0]        grant_idx;
    logic                    busy;
    logic                    err_timeout;

    // The arbiter owns the UART, so it is the master side.
    modport master (
        input  req, sensor_bus, tx_busy, tx_done,
        output ack, tx_start, tx_byte, grant_idx, busy, err_timeout
    );

    modport slave (
        output req, sensor_bus, tx_busy, tx_done,
        input  ack, tx_start, tx_byte, grant_idx, busy, err_timeout
    );
endinterface

`default_nettype wire

// File: rtl/sensor_uart_arbiter_rr_pick.sv
// ============================================================================
//  Module : rr_pick
//  Brief  : Combinational round-robin select: first set req at/after rr_ptr.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module rr_pick #(
    parameter int N_SENSORS = 8,
    parameter int IDX_W     = 3
) (
    input  wire logic [N_SENSORS-1:0] req,
    input  wire logic [IDX_W-1:0]     rr_ptr,
    output logic                      any,
    output logic [IDX_W-1:0]          idx
);

    always_comb begin
        logic [IDX_W-1:0] cand;
        cand = '0;
        any  = 1'b0;
        idx  = rr_ptr;
        // N_SENSORS is a power of two, so the index add wraps for free.
        for (int i = 0; i < N_SENSORS; i++) begin
            cand = rr_ptr + IDX_W'(i);
            if (!any && req[cand]) begin
                any = 1'b1;
                idx = cand;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/sensor_uart_arbiter.sv
// ============================================================================
//  Module : sensor_uart_arbiter
//  Brief  : Round-robin share of one byte UART among sensor controllers.
//           Optional TX timeout enabled by macro SENSOR_ARB_TIMEOUT_EN.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module sensor_uart_arbiter
    import sensor_arb_pkg::*;
#(
    parameter int N_SENSORS   = 8,
    parameter int IDX_W       = 3,
    parameter int TIMEOUT_CYC = 1_000_000
) (
    input  wire logic            clk,
    input  wire logic            rst,
    sensor_uart_arbiter_if.master bus
);

    arb_state_t          r_state;
    arb_state_t          w_state_nxt;
    logic [IDX_W-1:0]    r_rr_ptr;
    logic [IDX_W-1:0]    r_grant;
    logic [WORD_W-1:0]   r_frame;
    logic                w_any;
    logic [IDX_W-1:0]    w_idx;
    logic                w_timeout;
    logic                w_err;
    logic                w_in_wait;

    assign w_in_wait = (r_state == WAIT_HI) || (r_state == WAIT_LO);

    rr_pick #(
        .N_SENSORS (N_SENSORS),
        .IDX_W     (IDX_W)
    ) u_rr_pick (
        .req    (bus.req),
        .rr_ptr (r_rr_ptr),
        .any    (w_any),
        .idx    (w_idx)
    );

`ifdef SENSOR_ARB_TIMEOUT_EN
    localparam int TCNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    logic [TCNT_W-1:0] r_tcnt;
    logic              r_err;

    assign w_timeout = w_in_wait && !bus.tx_done &&
                       (r_tcnt == TCNT_W'(TIMEOUT_CYC - 1));
    assign w_err     = r_err;

    // Counter restarts whenever a WAIT state is (re-)entered.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tcnt <= '0;
            r_err  <= 1'b0;
        end else begin
            if (w_in_wait && (w_state_nxt == r_state))
                r_tcnt <= r_tcnt + 1'b1;
            else
                r_tcnt <= '0;
            if (w_timeout)
                r_err <= 1'b1;
        end
    end
`else
    assign w_timeout = 1'b0;
    assign w_err     = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst)
            r_state <= IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_any)        w_state_nxt = SEND_HI;
            SEND_HI: if (!bus.tx_busy) w_state_nxt = WAIT_HI;
            WAIT_HI: begin
                if (bus.tx_done)       w_state_nxt = SEND_LO;
                else if (w_timeout)    w_state_nxt = ACK;
            end
            SEND_LO: if (!bus.tx_busy) w_state_nxt = WAIT_LO;
            WAIT_LO: begin
                if (bus.tx_done || w_timeout) w_state_nxt = ACK;
            end
            ACK:                       w_state_nxt = IDLE;
            default:                   w_state_nxt = IDLE;
        endcase
    end

    // Frame and grant are frozen at grant time; later req/bus changes are ignored.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr <= '0;
            r_grant  <= '0;
            r_frame  <= '0;
        end else begin
            if ((r_state == IDLE) && w_any) begin
                r_grant <= w_idx;
                r_frame <= bus.sensor_bus[w_idx*WORD_W +: WORD_W];
            end
            if (r_state == ACK)
                r_rr_ptr <= r_grant + 1'b1;
        end
    end

    always_comb begin
        bus.tx_start    = 1'b0;
        bus.tx_byte     = '0;
        bus.ack         = '0;
        bus.busy        = (r_state != IDLE);
        bus.grant_idx   = r_grant;
        bus.err_timeout = w_err;
        if (((r_state == SEND_HI) || (r_state == SEND_LO)) && !bus.tx_busy) begin
            bus.tx_start = 1'b1;
            bus.tx_byte  = frame_byte(r_frame, r_state == SEND_LO);
        end
        if (r_state == ACK)
            bus.ack[r_grant] = 1'b1;
    end

endmodule

`default_nettype wire

// File: tb/tb_sensor_uart_arbiter.sv
// ============================================================================
//  Module : tb_sensor_uart_arbiter
//  Brief  : Directed scoreboard bench for sensor_uart_arbiter with a UART model.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_sensor_uart_arbiter;

    localparam int N  = 8;
    localparam int IW = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sensor_uart_arbiter_if #(.N_SENSORS(N), .IDX_W(IW)) bus ();

    sensor_uart_arbiter #(
        .N_SENSORS   (N),
        .IDX_W       (IW),
        .TIMEOUT_CYC (100)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [N-1:0]    req_r      = '0;
    logic [N*16-1:0] sb         = '0;
    logic            force_busy = 1'b0;
    logic            stray_done = 1'b0;
    logic            uart_mute  = 1'b0;
    logic            u_busy, u_done;
    int              u_cnt;
    int              done_dly   = 10;

    assign bus.req        = req_r;
    assign bus.sensor_bus = sb;
    assign bus.tx_busy    = u_busy | force_busy;
    assign bus.tx_done    = u_done | stray_done;

    // UART model: busy from tx_start until done_dly cycles later, then one done pulse.
    always @(posedge clk) begin
        u_done <= 1'b0;
        if (rst) begin
            u_busy <= 1'b0;
            u_cnt  <= 0;
        end else if (!uart_mute && bus.tx_start) begin
            u_busy <= 1'b1;
            u_cnt  <= done_dly - 1;
        end else if (u_busy) begin
            if (u_cnt == 0) begin
                u_busy <= 1'b0;
                u_done <= 1'b1;
            end else begin
                u_cnt <= u_cnt - 1;
            end
        end
    end

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;
    int n_starts = 0;
    int n_acks   = 0;
    bit timeout_mode = 1'b0;
    bit last_done    = 1'b0;

    logic [7:0]   exp_bytes[$];
    logic [N-1:0] exp_acks[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic set_slice(input int s, input logic [15:0] v);
        sb[16*s +: 16] = v;
    endtask

    task automatic push_frame(input int s, input logic [15:0] f, input bit with_ack);
        exp_bytes.push_back(f[15:8]);
        exp_bytes.push_back(f[7:0]);
        if (with_ack)
            exp_acks.push_back(N'(1) << s);
    endtask

    task automatic wait_ack(input int bound);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < bound && !seen; i++) begin
            @(negedge clk);
            if (bus.ack != '0) seen = 1'b1;
        end
        check("ack_within_bound", 32'(seen), 1);
    endtask

    // Scoreboard side: every byte and ack the DUT emits is popped and compared.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.tx_start) begin
                n_starts++;
                check("start_while_tx_busy", 32'(bus.tx_busy), 0);
                if (exp_bytes.size() == 0)
                    check("tx_byte_expected", 32'(exp_bytes.size() != 0), 1);
                else
                    check("tx_byte", 32'(bus.tx_byte), 32'(exp_bytes.pop_front()));
            end
            if (bus.ack != '0) begin
                n_acks++;
                check("ack_onehot", 32'($onehot(bus.ack)), 1);
                if (exp_acks.size() == 0)
                    check("ack_expected", 32'(exp_acks.size() != 0), 1);
                else
                    check("ack", 32'(bus.ack), 32'(exp_acks.pop_front()));
                if (!timeout_mode)
                    check("ack_after_last_done", 32'(last_done), 1);
            end
            last_done = bus.tx_done;
        end else begin
            last_done = 1'b0;
        end
    end

    initial begin
        int starts_seen;
        int base;
        bit reached;
        logic [15:0] f;

        // Reset state
        tick();
        tick();
        rst = 1'b0;
        check("rst_busy",      32'(bus.busy), 0);
        check("rst_grant_idx", 32'(bus.grant_idx), 0);
        check("rst_tx_start",  32'(bus.tx_start), 0);
        check("rst_tx_byte",   32'(bus.tx_byte), 0);
        check("rst_ack",       32'(bus.ack), 0);
        check("rst_err",       32'(bus.err_timeout), 0);

        // Stray tx_done in IDLE has no effect
        stray_done = 1'b1;
        tick();
        stray_done = 1'b0;
        tick();
        check("stray_done_idle", 32'(bus.busy), 0);

        // Single requester, bus and req changed after grant
        set_slice(2, 16'hA55A);
        push_frame(2, 16'hA55A, 1'b1);
        req_r = 8'h04;
        tick();
        check("single_grant_idx", 32'(bus.grant_idx), 2);
        check("single_busy", 32'(bus.busy), 1);
        req_r = 8'h00;
        set_slice(2, 16'h0000);
        wait_ack(200);
        tick();
        check("single_idle_after_ack", 32'(bus.busy), 0);

        // Fairness from rr_ptr=0 with all requesting: 0..7 then 0
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int s = 0; s < N; s++) set_slice(s, {8'(8'h10 + s), 8'(8'h80 + s)});
        for (int k = 0; k <= N; k++) push_frame(k % N, sb[16*(k % N) +: 16], 1'b1);
        req_r = 8'hFF;
        for (int k = 0; k <= N; k++) wait_ack(200);
        req_r = 8'h00;
        tick();

        // Wrap: serve 6 so rr_ptr=7, then 7 wins over 0
        push_frame(6, sb[16*6 +: 16], 1'b1);
        req_r = 8'h40;
        tick();
        req_r = 8'h00;
        wait_ack(200);
        tick();
        push_frame(7, sb[16*7 +: 16], 1'b1);
        push_frame(0, sb[16*0 +: 16], 1'b1);
        req_r = 8'h81;
        tick();
        check("wrap_grant_first", 32'(bus.grant_idx), 7);
        wait_ack(200);
        wait_ack(200);
        req_r = 8'h00;
        tick();

        // Backpressure: 50 cycles of tx_busy, sensor_bus changes mid-frame
        set_slice(2, 16'hBEEF);
        push_frame(2, 16'hBEEF, 1'b1);
        force_busy = 1'b1;
        req_r = 8'h04;
        tick();
        check("bp_grant_idx", 32'(bus.grant_idx), 2);
        req_r = 8'h00;
        starts_seen = 0;
        for (int c = 0; c < 50; c++) begin
            if (bus.tx_start) starts_seen++;
            if (c == 25) set_slice(2, 16'h1234);
            tick();
        end
        check("bp_no_start", 32'(starts_seen), 0);
        base = n_starts;
        force_busy = 1'b0;
        wait_ack(200);
        check("bp_two_starts", 32'(n_starts - base), 2);
        tick();

        // Reset during WAIT_LO: no ack, outputs cleared
        set_slice(3, 16'hC33C);
        push_frame(3, 16'hC33C, 1'b0);
        base = n_starts;
        req_r = 8'h08;
        tick();
        req_r = 8'h00;
        reached = 1'b0;
        for (int i = 0; i < 100 && !reached; i++) begin
            @(negedge clk);
            if (n_starts == base + 2) reached = 1'b1;
        end
        check("rstmid_reached_lo", 32'(reached), 1);
        tick();
        check("rstmid_busy_before", 32'(bus.busy), 1);
        base = n_acks;
        rst = 1'b1;
        tick();
        check("rstmid_busy",     32'(bus.busy), 0);
        check("rstmid_grant",    32'(bus.grant_idx), 0);
        check("rstmid_tx_start", 32'(bus.tx_start), 0);
        check("rstmid_tx_byte",  32'(bus.tx_byte), 0);
        check("rstmid_ack",      32'(bus.ack), 0);
        rst = 1'b0;
        repeat (20) tick();
        check("rstmid_no_ack", 32'(n_acks - base), 0);

`ifdef SENSOR_ARB_TIMEOUT_EN
        // Timeout: UART never answers, sensor 4 acked anyway, then sensor 5 served
        f = 16'h4D4D;
        set_slice(4, f);
        exp_bytes.push_back(f[15:8]);
        exp_acks.push_back(8'h10);
        uart_mute = 1'b1;
        timeout_mode = 1'b1;
        req_r = 8'h10;
        tick();
        req_r = 8'h00;
        repeat (50) tick();
        check("to_err_not_early", 32'(bus.err_timeout), 0);
        wait_ack(300);
        check("to_err_set", 32'(bus.err_timeout), 1);
        tick();
        timeout_mode = 1'b0;
        uart_mute = 1'b0;
        set_slice(5, 16'h5E5E);
        push_frame(5, 16'h5E5E, 1'b1);
        req_r = 8'h20;
        tick();
        check("to_next_grant", 32'(bus.grant_idx), 5);
        req_r = 8'h00;
        wait_ack(200);
        tick();
        check("to_err_sticky", 32'(bus.err_timeout), 1);
`else
        f = 16'h0000;
        check("err_tied_low", 32'(bus.err_timeout) | 32'(f), 0);
`endif

        check("bytes_drained", 32'(exp_bytes.size()), 0);
        check("acks_drained",  32'(exp_acks.size()), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
